// File: rtl/rf_dbg_pkg.sv
// Shared nRF24L01 definitions: SPI opcodes, uplink frame limits and receiver FSM states.
package rf_dbg_pkg;

   localparam logic [7:0] R_RX_PAYLOAD  = 8'h61;
   localparam logic [7:0] W_STATUS      = 8'h27;
   localparam logic [7:0] RX_DR         = 8'h40;
   localparam logic [7:0] NOP           = 8'hFF;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
   localparam logic [7:0] MAX_DATA_LEN  = 8'd28;
   localparam int         FRAME_BYTES   = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_RD,
      ST_GAP,
      ST_CLR,
      ST_CHECK
   } rx_state_e;

endpackage

// File: rtl/rf_uplink_rx_module_if.sv
// Byte-engine handshake between the uplink receiver (master) and SPI_module (slave).
interface rf_uplink_rx_module_if;

   logic       SPI_En;
   logic [7:0] SPI_SBUF;
   logic [7:0] SPI_RBUF;
   logic       SPI_Dat_Rdy;
   logic       SPI_Busy;

   modport master (output SPI_En, SPI_SBUF, input SPI_RBUF, SPI_Dat_Rdy, SPI_Busy);
   modport slave  (input SPI_En, SPI_SBUF, output SPI_RBUF, SPI_Dat_Rdy, SPI_Busy);

endinterface

// File: rtl/rf_rx_frame_buf.sv
// Double-buffered 2x32x8 frame store: payload lands in the shadow bank, reads see the committed bank.
module rf_rx_frame_buf
   import rf_dbg_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_dat,
   input  logic       swap,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_dat
);

   localparam logic [4:0] RD_ADDR_MAX = 5'(MAX_DATA_LEN - 8'd1);

   logic [7:0] mem [2][FRAME_BYTES];
   logic       sel_q;

   // NOTE: storage arrays carry no reset; only the bank select and read register do.
   always_ff @(posedge CLK) begin
      if (wr_en) mem[~sel_q][wr_addr] <= wr_dat;
   end

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sel_q  <= 1'b0;
         rd_dat <= '0;
      end else begin
         if (swap) sel_q <= ~sel_q;
         rd_dat <= (rd_addr > RD_ADDR_MAX) ? 8'h00 : mem[sel_q][5'(rd_addr + 5'd3)];
      end
   end

endmodule

// File: rtl/rf_uplink_rx_module.sv
// nRF24L01 uplink receiver: on IRQ reads the RX payload, clears RX_DR, validates and publishes the command.
// Optional: define RF_RX_CHKSUM_EN to require byte 31 to equal the wrap-around sum of bytes 0..30.
module rf_uplink_rx_module
   import rf_dbg_pkg::*;
#(
   parameter logic [5:0]  PAYLOAD_LEN = 6'd32,
   parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
   parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  En,
   input  logic                  NRF_IRQ,
   output logic                  NRF_CE,
   output logic                  NRF_CSN,
   rf_uplink_rx_module_if.master spi,
   output logic                  Cmd_Rdy,
   output logic [7:0]            Cmd_Id,
   output logic [4:0]            Cmd_Len,
   input  logic [4:0]            Cmd_Rd_Addr,
   output logic [7:0]            Cmd_Rd_Dat,
   output logic [7:0]            Err_Cnt
);

   localparam logic [5:0] LAST_IDX = 6'(PAYLOAD_LEN - 6'd1);

   rx_state_e   state_q, state_d;
   logic        irq_meta, irq_sync;
   logic        csn_q, csn_d;
   logic        spi_en_q, spi_en_d;
   logic [7:0]  sbuf_q, sbuf_d;
   logic        in_flight_q, in_flight_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        gap_q, gap_d;
   logic [15:0] tmo_q, tmo_d;
   logic [7:0]  err_q;
   logic [7:0]  hdr_sync_q, hdr_id_q, hdr_len_q;
   logic [7:0]  cmd_id_q;
   logic [4:0]  cmd_len_q;
   logic        cmd_rdy_q;
   logic        xfer, byte_done, buf_we, commit, err_inc, chk_ok, frame_ok;
   logic [7:0]  tx_byte;

   assign NRF_CE       = En & ~RST;
   assign NRF_CSN      = csn_q;
   assign spi.SPI_En   = spi_en_q;
   assign spi.SPI_SBUF = sbuf_q;
   assign Cmd_Rdy      = cmd_rdy_q;
   assign Cmd_Id       = cmd_id_q;
   assign Cmd_Len      = cmd_len_q;
   assign Err_Cnt      = err_q;

`ifdef RF_RX_CHKSUM_EN
   logic [7:0] sum_q, chk_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sum_q <= '0;
         chk_q <= '0;
      end else if (state_q == ST_CMD) begin
         sum_q <= '0;
      end else if (buf_we) begin
         if (cnt_q == LAST_IDX) chk_q <= spi.SPI_RBUF;
         else                   sum_q <= sum_q + spi.SPI_RBUF;
      end
   end

   assign chk_ok = (sum_q == chk_q);
`else
   assign chk_ok = 1'b1;
`endif

   assign frame_ok  = (hdr_sync_q == SYNC_BYTE) && (hdr_len_q <= MAX_DATA_LEN) && chk_ok;
   assign xfer      = (state_q == ST_CMD) || (state_q == ST_RD) || (state_q == ST_CLR);
   assign byte_done = in_flight_q && spi.SPI_Dat_Rdy;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      csn_d       = csn_q;
      spi_en_d    = 1'b0;
      sbuf_d      = sbuf_q;
      in_flight_d = in_flight_q;
      cnt_d       = cnt_q;
      gap_d       = gap_q;
      tmo_d       = tmo_q;
      buf_we      = 1'b0;
      commit      = 1'b0;
      err_inc     = 1'b0;

      unique case (state_q)
         ST_CMD:  tx_byte = R_RX_PAYLOAD;
         ST_CLR:  tx_byte = cnt_q[0] ? RX_DR : W_STATUS;
         default: tx_byte = NOP;
      endcase

      // One byte in flight: start only on an idle engine, then wait for completion.
      if (xfer && !in_flight_q && !spi.SPI_Busy) begin
         spi_en_d    = 1'b1;
         sbuf_d      = tx_byte;
         in_flight_d = 1'b1;
         tmo_d       = TIMEOUT_CYC - 16'd1;
      end else if (in_flight_q) begin
         if (spi.SPI_Dat_Rdy) in_flight_d = 1'b0;
         else if (tmo_q != 16'd0) tmo_d = tmo_q - 16'd1;
      end

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (En && !irq_sync) begin
               state_d = ST_CMD;
               csn_d   = 1'b0;
            end
         end
         ST_CMD: begin
            if (byte_done) begin
               state_d = ST_RD;
               cnt_d   = '0;
            end
         end
         ST_RD: begin
            if (byte_done) begin
               buf_we = 1'b1;
               if (cnt_q == LAST_IDX) begin
                  state_d = ST_GAP;
                  csn_d   = 1'b1;
                  gap_d   = 1'b0;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         ST_GAP: begin
            if (gap_q) begin
               state_d = ST_CLR;
               csn_d   = 1'b0;
               cnt_d   = '0;
            end else begin
               gap_d = 1'b1;
            end
         end
         ST_CLR: begin
            if (byte_done) begin
               if (cnt_q[0]) begin
                  state_d = ST_CHECK;
                  csn_d   = 1'b1;
               end else begin
                  cnt_d = 6'd1;
               end
            end
         end
         ST_CHECK: begin
            commit  = frame_ok;
            err_inc = !frame_ok;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A silent byte engine aborts the frame without touching the committed bank.
      if (in_flight_q && !spi.SPI_Dat_Rdy && tmo_q == 16'd0) begin
         state_d     = ST_IDLE;
         csn_d       = 1'b1;
         in_flight_d = 1'b0;
         buf_we      = 1'b0;
         err_inc     = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         irq_meta    <= 1'b1;
         irq_sync    <= 1'b1;
         csn_q       <= 1'b1;
         spi_en_q    <= 1'b0;
         sbuf_q      <= '0;
         in_flight_q <= 1'b0;
         cnt_q       <= '0;
         gap_q       <= 1'b0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         irq_meta    <= NRF_IRQ;
         irq_sync    <= irq_meta;
         csn_q       <= csn_d;
         spi_en_q    <= spi_en_d;
         sbuf_q      <= sbuf_d;
         in_flight_q <= in_flight_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         tmo_q       <= tmo_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hdr_sync_q <= '0;
         hdr_id_q   <= '0;
         hdr_len_q  <= '0;
         cmd_id_q   <= '0;
         cmd_len_q  <= '0;
         cmd_rdy_q  <= 1'b0;
         err_q      <= '0;
      end else begin
         if (buf_we) begin
            if (cnt_q == 6'd0) hdr_sync_q <= spi.SPI_RBUF;
            if (cnt_q == 6'd1) hdr_id_q   <= spi.SPI_RBUF;
            if (cnt_q == 6'd2) hdr_len_q  <= spi.SPI_RBUF;
         end
         if (commit) begin
            cmd_id_q  <= hdr_id_q;
            cmd_len_q <= hdr_len_q[4:0];
         end
         cmd_rdy_q <= commit;
         if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
      end
   end

   rf_rx_frame_buf u_frame_buf (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (buf_we),
      .wr_addr (cnt_q[4:0]),
      .wr_dat  (spi.SPI_RBUF),
      .swap    (commit),
      .rd_addr (Cmd_Rd_Addr),
      .rd_dat  (Cmd_Rd_Dat)
   );

endmodule

// File: tb/tb_rf_uplink_rx_module.sv
// Directed bench for rf_uplink_rx_module with a behavioural nRF24L01 + SPI byte-engine model.
`timescale 1ns/1ps
module tb_rf_uplink_rx_module;
   import rf_dbg_pkg::*;

   typedef logic [31:0][7:0] frame_t;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       En = 1'b0;
   logic       NRF_IRQ = 1'b1;
   logic [4:0] Cmd_Rd_Addr = '0;
   logic       NRF_CE, NRF_CSN, Cmd_Rdy;
   logic [7:0] Cmd_Id, Cmd_Rd_Dat, Err_Cnt;
   logic [4:0] Cmd_Len;

   rf_uplink_rx_module_if spi_bus ();

   rf_uplink_rx_module dut (
      .CLK         (CLK),
      .RST         (RST),
      .En          (En),
      .NRF_IRQ     (NRF_IRQ),
      .NRF_CE      (NRF_CE),
      .NRF_CSN     (NRF_CSN),
      .spi         (spi_bus),
      .Cmd_Rdy     (Cmd_Rdy),
      .Cmd_Id      (Cmd_Id),
      .Cmd_Len     (Cmd_Len),
      .Cmd_Rd_Addr (Cmd_Rd_Addr),
      .Cmd_Rd_Dat  (Cmd_Rd_Dat),
      .Err_Cnt     (Err_Cnt)
   );

   always #5 CLK = ~CLK;

   int         n_assert = 0;
   int         n_fail   = 0;
   int         rdy_cnt  = 0;
   frame_t     fq[$];
   logic [7:0] mosi[$];
   bit         hold = 1'b0;

   always @(negedge CLK) if (Cmd_Rdy === 1'b1) rdy_cnt++;

   // Radio + byte engine: serves the head frame, pops it on the RX_DR clear, IRQ low while frames queue.
   initial begin
      int         idx = 0;
      int         dly = 0;
      logic [7:0] op0 = 8'h00;
      logic [7:0] resp = 8'h00;
      spi_bus.SPI_RBUF    = 8'h00;
      spi_bus.SPI_Dat_Rdy = 1'b0;
      spi_bus.SPI_Busy    = 1'b0;
      forever begin
         @(posedge CLK); #1;
         spi_bus.SPI_Dat_Rdy = 1'b0;
         if (dly > 0) begin
            dly--;
            if (dly == 0) begin
               spi_bus.SPI_Busy    = 1'b0;
               spi_bus.SPI_Dat_Rdy = 1'b1;
               spi_bus.SPI_RBUF    = resp;
            end
         end
         if (NRF_CSN === 1'b1) idx = 0;
         if (spi_bus.SPI_En === 1'b1) begin
            mosi.push_back(spi_bus.SPI_SBUF);
            if (idx == 0) begin
               op0  = spi_bus.SPI_SBUF;
               resp = 8'h40;
            end else if (op0 == R_RX_PAYLOAD && idx <= 32 && fq.size() > 0) begin
               resp = fq[0][idx-1];
            end else begin
               resp = 8'h0E;
            end
            if (op0 == W_STATUS && idx == 1 && spi_bus.SPI_SBUF == RX_DR && fq.size() > 0)
               void'(fq.pop_front());
            if (hold && op0 == R_RX_PAYLOAD && idx == 11) begin
               if (fq.size() > 0) void'(fq.pop_front());
            end else begin
               dly              = 2;
               spi_bus.SPI_Busy = 1'b1;
            end
            idx++;
         end
         NRF_IRQ = (fq.size() == 0);
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
      end
   endtask

   task automatic wait_rdy(input string tag, input int target);
      for (int i = 0; i < 3000 && rdy_cnt < target; i++) tick(1);
      tick(2);
      check(tag, rdy_cnt, target);
   endtask

   task automatic wait_drained(input string tag);
      for (int i = 0; i < 3000 && fq.size() != 0; i++) tick(1);
      tick(10);
      check(tag, fq.size(), 0);
   endtask

   task automatic rd(input string tag, input logic [4:0] addr, input logic [7:0] exp);
      Cmd_Rd_Addr = addr;
      tick(1);
      check(tag, Cmd_Rd_Dat, exp);
   endtask

   function automatic frame_t seal(input frame_t f, input logic [7:0] adj);
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 31; i++) s = s + f[i];
      f[31] = s + adj;
      return f;
   endfunction

   function automatic frame_t mk(input logic [7:0] b0, input logic [7:0] id, input logic [7:0] len,
                                 input logic [31:0] data);
      frame_t f = '0;
      f[0] = b0; f[1] = id; f[2] = len;
      f[3] = data[31:24]; f[4] = data[23:16]; f[5] = data[15:8]; f[6] = data[7:0];
      return f;
   endfunction

   initial begin
      frame_t f;
      int     ff_cnt;
      int     exp_rdy = 0;
      int     exp_err = 0;

      // Reset values
      tick(3);
      check("rst_csn", NRF_CSN, 1);
      check("rst_ce", NRF_CE, 0);
      check("rst_spi_en", spi_bus.SPI_En, 0);
      check("rst_sbuf", spi_bus.SPI_SBUF, 0);
      check("rst_rdy", Cmd_Rdy, 0);
      check("rst_id", Cmd_Id, 0);
      check("rst_len", Cmd_Len, 0);
      check("rst_rd_dat", Cmd_Rd_Dat, 0);
      check("rst_err", Err_Cnt, 0);
      RST = 1'b0;
      En  = 1'b1;
      tick(2);
      check("ce_follows_en", NRF_CE, 1);

      // 1: valid frame A5 03 04 11 22 33 44 .. sum
      mosi.delete();
      fq.push_back(seal(mk(8'hA5, 8'h03, 8'h04, 32'h11223344), 8'h00));
      exp_rdy = 1;
      wait_rdy("t1_rdy", exp_rdy);
      check("t1_id", Cmd_Id, 8'h03);
      check("t1_len", Cmd_Len, 5'd4);
      check("t1_err", Err_Cnt, 0);
      check("t1_mosi_len", mosi.size(), 35);
      check("t1_mosi_cmd", mosi[0], 8'h61);
      ff_cnt = 0;
      for (int i = 1; i <= 32; i++) if (mosi[i] == 8'hFF) ff_cnt++;
      check("t1_mosi_nop", ff_cnt, 32);
      check("t1_mosi_wstat", mosi[33], 8'h27);
      check("t1_mosi_rxdr", mosi[34], 8'h40);
      check("t1_csn_idle", NRF_CSN, 1);
      rd("t1_rd0", 5'd0, 8'h11);
      rd("t1_rd1", 5'd1, 8'h22);
      rd("t1_rd2", 5'd2, 8'h33);
      rd("t1_rd3", 5'd3, 8'h44);
      rd("t1_rd4", 5'd4, 8'h00);

      // 2: bad sync byte
      fq.push_back(seal(mk(8'h5A, 8'h07, 8'h02, 32'h99887766), 8'h00));
      wait_drained("t2_drain");
      exp_err = 1;
      check("t2_no_rdy", rdy_cnt, exp_rdy);
      check("t2_err", Err_Cnt, exp_err);
      check("t2_id_kept", Cmd_Id, 8'h03);
      rd("t2_rd0_kept", 5'd0, 8'h11);

      // Length boundary: 28 accepted, addr 27 is byte 30, addr >27 reads zero
      f = mk(8'hA5, 8'h07, 8'd28, 32'h55667788);
      f[30] = 8'h9C;
      fq.push_back(seal(f, 8'h00));
      exp_rdy++;
      wait_rdy("len28_rdy", exp_rdy);
      check("len28_len", Cmd_Len, 5'd28);
      check("len28_id", Cmd_Id, 8'h07);
      rd("len28_rd27", 5'd27, 8'h9C);
      rd("len28_rd28", 5'd28, 8'h00);
      rd("len28_rd31", 5'd31, 8'h00);
      rd("len28_rd0", 5'd0, 8'h55);

      // Length 29 rejected
      fq.push_back(seal(mk(8'hA5, 8'h08, 8'd29, 32'h01020304), 8'h00));
      wait_drained("len29_drain");
      exp_err++;
      check("len29_no_rdy", rdy_cnt, exp_rdy);
      check("len29_err", Err_Cnt, exp_err);
      check("len29_len_kept", Cmd_Len, 5'd28);

      // 3: checksum off by one
      fq.push_back(seal(mk(8'hA5, 8'h09, 8'h02, 32'hABCD0000), 8'h01));
      wait_drained("t3_drain");
`ifdef RF_RX_CHKSUM_EN
      exp_err++;
      check("t3_rdy", rdy_cnt, exp_rdy);
      check("t3_err", Err_Cnt, exp_err);
      check("t3_id_kept", Cmd_Id, 8'h07);
`else
      exp_rdy++;
      check("t3_rdy", rdy_cnt, exp_rdy);
      check("t3_err", Err_Cnt, exp_err);
      check("t3_id", Cmd_Id, 8'h09);
      rd("t3_rd0", 5'd0, 8'hAB);
`endif

      // 5: two queued frames read back-to-back
      fq.push_back(seal(mk(8'hA5, 8'h21, 8'h01, 32'hC1000000), 8'h00));
      fq.push_back(seal(mk(8'hA5, 8'h22, 8'h02, 32'hD1D20000), 8'h00));
      exp_rdy += 2;
      wait_rdy("t5_rdy", exp_rdy);
      check("t5_id", Cmd_Id, 8'h22);
      check("t5_len", Cmd_Len, 5'd2);
      check("t5_err", Err_Cnt, exp_err);
      rd("t5_rd0", 5'd0, 8'hD1);
      rd("t5_rd1", 5'd1, 8'hD2);

      // 4: byte engine goes silent after payload byte 10
      hold = 1'b1;
      fq.push_back(seal(mk(8'hA5, 8'h33, 8'h01, 32'hEE000000), 8'h00));
      for (int i = 0; i < 3000 && fq.size() != 0; i++) tick(1);
      check("t4_stall_reached", fq.size(), 0);
      tick(49975);
      check("t4_csn_before", NRF_CSN, 0);
      tick(40);
      exp_err++;
      check("t4_csn_after", NRF_CSN, 1);
      check("t4_err", Err_Cnt, exp_err);
      check("t4_no_rdy", rdy_cnt, exp_rdy);
      check("t4_id_kept", Cmd_Id, 8'h22);
      rd("t4_rd0_kept", 5'd0, 8'hD1);
      tick(20);
      check("t4_idle_csn", NRF_CSN, 1);
      hold = 1'b0;

      // 6: reset during RD, then the same frame is re-read
      mosi.delete();
      fq.push_back(seal(mk(8'hA5, 8'h44, 8'h03, 32'h4A4B4C00), 8'h00));
      for (int i = 0; i < 3000 && mosi.size() < 8; i++) tick(1);
      check("t6_in_rd", mosi.size(), 8);
      #2;
      RST = 1'b1;
      #1;
      check("t6_rst_csn", NRF_CSN, 1);
      check("t6_rst_ce", NRF_CE, 0);
      check("t6_rst_err", Err_Cnt, 0);
      check("t6_rst_id", Cmd_Id, 0);
      tick(2);
      RST = 1'b0;
      exp_rdy++;
      wait_rdy("t6_rdy", exp_rdy);
      check("t6_id", Cmd_Id, 8'h44);
      check("t6_len", Cmd_Len, 5'd3);
      check("t6_err", Err_Cnt, 0);
      rd("t6_rd0", 5'd0, 8'h4A);
      rd("t6_rd2", 5'd2, 8'h4C);
      wait_drained("t6_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
